// File: rtl/tu_vec_sequencer.sv
// tu_vec_sequencer: drives a combinational 4-lane BF16 tensor unit through a
// packed dot-product accumulation (acc += A[k]*B[k] per lane), with optional
// ReLU on the final accumulator, then writes the 64-bit result to memory.
//
// Handshake: start is a command-valid qualifier sampled only in IDLE; there is
// no ready signal, and busy=1 means any start is ignored (never queued). done
// is a one-cycle pulse in DONE; the next start can be accepted the cycle after.
// abort is a synchronous cancel honoured in RD, ACC, RELU and WB only.
module tu_vec_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr_a,
  output logic [ADDR_W-1:0] mem_rd_addr_b,
  input  logic [63:0]       mem_rdata_a,
  input  logic [63:0]       mem_rdata_b,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  output logic [63:0]       tu_rs1,
  output logic [63:0]       tu_rs2,
  output logic [63:0]       tu_rs3,
  output logic [5:0]        tu_op,
  input  logic [63:0]       tu_result,
  output logic [63:0]       result,
  output logic [2:0]        dbg_state
);

  localparam logic [5:0] TU_FMA  = 6'b010001;
  localparam logic [5:0] TU_RELU = 6'b011000;
  localparam logic [5:0] TU_NOP  = 6'b000000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Command fields captured at accept time so the caller may change them.
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              relu_q;

  logic [63:0]       acc_q;
  logic [LEN_W-1:0]  idx_q;

  // One extra bit so idx+1 never overflows before the compare against len.
  logic [LEN_W:0]    idx_inc;
  logic              more_elems;

  assign idx_inc    = {1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1};
  assign more_elems = idx_inc < {1'b0, len_q};
  assign dbg_state  = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other transition in the busy states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0)    state_d = RD;
          else if (relu_en) state_d = RELU;
          else              state_d = WB;
        end
      end
      RD: begin
        if (abort) state_d = IDLE;
        else       state_d = ACC;
      end
      ACC: begin
        if (abort)           state_d = IDLE;
        else if (more_elems) state_d = RD;
        else if (relu_q)     state_d = RELU;
        else                 state_d = WB;
      end
      RELU: begin
        if (abort) state_d = IDLE;
        else       state_d = WB;
      end
      WB: begin
        if (abort) state_d = IDLE;
        else       state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: strobes/opcodes from state, operand muxes from registers.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = 1'b0;
    mem_rd_en     = 1'b0;
    mem_rd_addr_a = '0;
    mem_rd_addr_b = '0;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    tu_op         = TU_NOP;
    tu_rs1        = '0;
    tu_rs2        = '0;
    tu_rs3        = '0;
    case (state_q)
      RD: begin
        // Address arithmetic wraps naturally at ADDR_W bits.
        mem_rd_en     = 1'b1;
        mem_rd_addr_a = a_base_q + ADDR_W'(idx_q);
        mem_rd_addr_b = b_base_q + ADDR_W'(idx_q);
      end
      ACC: begin
        tu_op  = TU_FMA;
        tu_rs1 = mem_rdata_a;
        tu_rs2 = mem_rdata_b;
        tu_rs3 = acc_q;
      end
      RELU: begin
        tu_op  = TU_RELU;
        tu_rs1 = acc_q;
      end
      WB: begin
        // The write strobe is Moore, so it still fires in an aborted WB cycle.
        mem_wr_en   = 1'b1;
        mem_wr_addr = dst_q;
        mem_wr_data = acc_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: command latch, accumulator, element index, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_base_q <= '0;
      b_base_q <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      result   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_base_q <= a_base;
            b_base_q <= b_base;
            dst_q    <= dst_addr;
            len_q    <= len;
            relu_q   <= relu_en;
            acc_q    <= '0;
            idx_q    <= '0;
          end
        end
        ACC: begin
          if (!abort) begin
            acc_q <= tu_result;
            idx_q <= idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        RELU: begin
          if (!abort) acc_q <= tu_result;
        end
        WB: begin
          // An aborted writeback must leave the previous result visible.
          if (!abort) result <= acc_q;
        end
        default: ;
      endcase
    end
  end

endmodule
